// File: rtl/motion_map_pkg.sv
// motion_map_pkg: shared defaults and packer state type for motion_map_packer
package motion_map_pkg;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 48;
  localparam int DEF_WORD_W = 32;
  typedef enum logic {PACK, HOLD} pack_state_t;
endpackage

// File: rtl/motion_map_packer_if.sv
// motion_map_packer_if: motion-bit input stream and packed-word output stream
interface motion_map_packer_if import motion_map_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) ();
  logic in_valid, in_motion, in_ready;
  logic out_valid, out_eol, out_eof, out_ready;
  logic [WORD_W-1:0] out_data;
  modport master (
    output in_valid, in_motion, out_ready,
    input in_ready, out_valid, out_data, out_eol, out_eof
  );
  modport slave (
    input in_valid, in_motion, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_eof
  );
endinterface

// File: rtl/motion_map_packer.sv
// motion_map_packer: packs raster motion bits LSB-first into WORD_W words with eol/eof tags; MMP_STATS_EN adds per-frame motion count
module motion_map_packer import motion_map_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WORD_W = DEF_WORD_W,
  localparam int CNT_W = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  motion_map_packer_if.slave bus,
  output logic frame_done,
  output logic [CNT_W-1:0] frame_motion_count
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(WORD_W);
  pack_state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] pos;
  logic [WORD_W-1:0] acc, word_n;
  logic accept, hs, line_end, frame_end, close;
  assign bus.in_ready = enable && !clear && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign hs = bus.out_valid && bus.out_ready;
  assign line_end = col == CW'(IMG_W - 1);
  assign frame_end = line_end && row == RW'(IMG_H - 1);
  assign close = accept && (line_end || pos == PW'(WORD_W - 1));
  assign word_n = acc | (WORD_W'(bus.in_motion) << pos);
  always_comb
    state_n = clear ? PACK :
              (state == PACK && close && !bus.out_ready) ? HOLD :
              (state == HOLD && hs) ? PACK : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PACK;
      col <= '0;
      row <= '0;
      pos <= '0;
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_eol <= 1'b0;
      bus.out_eof <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      frame_done <= hs && bus.out_eof;
      if (clear) begin
        col <= '0;
        row <= '0;
        pos <= '0;
        acc <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        if (hs) bus.out_valid <= 1'b0;
        if (accept) begin
          col <= line_end ? '0 : col + CW'(1);
          if (line_end) row <= frame_end ? '0 : row + RW'(1);
          acc <= close ? '0 : word_n;
          pos <= close ? '0 : pos + PW'(1);
          if (close) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= word_n;
            bus.out_eol <= line_end;
            bus.out_eof <= frame_end;
          end
        end
      end
    end
`ifdef MMP_STATS_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      frame_motion_count <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= frame_end ? '0 : cnt + CNT_W'(bus.in_motion);
      if (frame_end) frame_motion_count <= cnt + CNT_W'(bus.in_motion);
    end
`else
  assign frame_motion_count = '0;
`endif
endmodule

// File: tb/tb_motion_map_packer.sv
// tb_motion_map_packer: table-driven lines plus corner sequences, scoreboard of expected words
module tb_motion_map_packer;
  typedef struct packed {logic [31:0] d; logic eol; logic eof;} exp_t;
  typedef struct {logic [39:0] bits; logic [31:0] w0; logic [31:0] w1; logic eof;} vec_t;
  logic clk = 1'b0;
  logic rst_n, enable, clear;
  logic frame_done;
  logic [6:0] fmc;
  exp_t sb[$];
  vec_t tbl[6];
  int n_vec = 0, n_bad = 0, popped = 0, fd_cnt = 0;
  logic bp_en = 1'b0;
  motion_map_packer_if #(.WORD_W(32)) bus ();
  motion_map_packer #(.IMG_W(40), .IMG_H(2), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .bus(bus), .frame_done(frame_done), .frame_motion_count(fmc)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word got %h expected none", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", {30'b0, bus.out_data, bus.out_eol, bus.out_eof}, {30'b0, e.d, e.eol, e.eof});
        popped++;
      end
    end
    if (frame_done) fd_cnt++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic m);
    logic ok = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_motion = m;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else step();
    end
    if (ok) step();
    else check("in_ready_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_bits(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask
  task automatic send_line(input logic [39:0] v, input logic [31:0] w0, input logic [31:0] w1, input logic eof);
    sb.push_back('{d: w0, eol: 1'b0, eof: 1'b0});
    send_bits(v, 32);
    sb.push_back('{d: w1, eol: 1'b1, eof: eof});
    send_bits({32'b0, v[39:32]}, 8);
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    step();
  endtask
  task automatic pulse_clear();
    step();
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    clear = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_eol_eof"}, {62'b0, bus.out_eol, bus.out_eof}, 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_fmc"}, 64'(fmc), 64'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, f0;
    tbl[0] = '{40'hA5_1234_5678, 32'h1234_5678, 32'h0000_00A5, 1'b1};
    tbl[1] = '{40'h55_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0055, 1'b0};
    tbl[2] = '{40'h00_0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[3] = '{40'hFF_8000_0001, 32'h8000_0001, 32'h0000_00FF, 1'b0};
    tbl[4] = '{40'h3C_DEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_003C, 1'b1};
    tbl[5] = '{40'h81_0F0F_0F0F, 32'h0F0F_0F0F, 32'h0000_0081, 1'b0};
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_motion = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    enable = 1'b1;
    bus.out_ready = 1'b0;
    send_bits(40'hFF_FFFF_FFFF, 32);
    @(negedge clk);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_data", 64'(bus.out_data), 64'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst_stall");
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_bits(40'h3FF, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst_10");
    step();
    rst_n = 1'b1;
    send_line(40'h00_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) begin
      bp_en = (i >= 2);
      send_line(tbl[i].bits, tbl[i].w0, tbl[i].w1, tbl[i].eof);
    end
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("table_frames", 64'(fd_cnt), 64'd3);
    bus.out_ready = 1'b0;
    sb.push_back('{d: 32'hCAFE_BABE, eol: 1'b0, eof: 1'b0});
    send_bits({8'h0, 32'hCAFE_BABE}, 32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_data", 64'(bus.out_data), 64'hCAFE_BABE);
    end
    step();
    bus.out_ready = 1'b1;
    sb.push_back('{d: 32'h3, eol: 1'b1, eof: 1'b1});
    send_bits(40'h3, 8);
    drain();
    check("hold_frames", 64'(fd_cnt), 64'd4);
    p0 = popped;
    f0 = fd_cnt;
    send_line(40'h0F_0000_0001, 32'h0000_0001, 32'h0000_000F, 1'b0);
    send_line(40'hF0_8000_0000, 32'h8000_0000, 32'h0000_00F0, 1'b1);
    drain();
    check("frame_words", 64'(popped - p0), 64'd4);
    check("frame_done_once", 64'(fd_cnt - f0), 64'd1);
    sb.push_back('{d: 32'h1, eol: 1'b0, eof: 1'b0});
    send_bits(40'h1, 32);
    sb.push_back('{d: 32'h0, eol: 1'b1, eof: 1'b0});
    send_bits(40'h0, 8);
    drain();
    bus.out_ready = 1'b0;
    send_bits(40'hFF_FFFF_FFFF, 32);
    pulse_clear();
    @(negedge clk);
    check("clear_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.out_ready = 1'b1;
    send_bits(40'h3FF, 10);
    pulse_clear();
    sb.push_back('{d: 32'hF0, eol: 1'b0, eof: 1'b0});
    send_bits(40'hF0, 32);
    sb.push_back('{d: 32'h0, eol: 1'b1, eof: 1'b0});
    send_bits(40'h0, 8);
    drain();
    bus.out_ready = 1'b0;
    sb.push_back('{d: 32'h1234, eol: 1'b0, eof: 1'b0});
    send_bits(40'h1234, 32);
    step();
    enable = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("disabled_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("disabled_drained", 64'(sb.size()), 64'd0);
    step();
    enable = 1'b1;
    sb.push_back('{d: 32'h7, eol: 1'b1, eof: 1'b1});
    send_bits(40'h7, 8);
    drain();
    check("enable_frames", 64'(fd_cnt), 64'd6);
    pulse_clear();
    send_line(40'h1F_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_001F, 1'b0);
    send_line(40'h0, 32'h0, 32'h0, 1'b1);
    drain();
`ifdef MMP_STATS_EN
    check("motion_count_37", 64'(fmc), 64'd37);
`else
    check("motion_count_off", 64'(fmc), 64'd0);
`endif
    send_line(40'h00_0000_0007, 32'h7, 32'h0, 1'b0);
    send_line(40'h0, 32'h0, 32'h0, 1'b1);
    drain();
`ifdef MMP_STATS_EN
    check("motion_count_3", 64'(fmc), 64'd3);
`else
    check("motion_count_off2", 64'(fmc), 64'd0);
`endif
    check("total_frames", 64'(fd_cnt), 64'd8);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/motion_map_packer.md
MOTION_MAP_PACKER -- requirements
Module: motion_map_packer

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per line (2..4095).
REQ-002 SHALL have parameter IMG_H, default 48, lines per frame (1..4095).
REQ-003 SHALL have parameter WORD_W, default 32, packed output word width (8..64).
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have ports enable  in  1  packer enable; clear  in  1  sync frame resync.
REQ-006 SHALL have ports in_valid  in  1  motion bit valid; in_motion  in  1  per-pixel motion flag; in_ready  out  1  bit accepted when in_valid&&in_ready.
REQ-007 SHALL have ports out_valid  out  1; out_data  out  WORD_W  packed bits; out_eol  out  1  word ends line; out_eof  out  1  word ends frame; out_ready  in  1.
REQ-008 SHALL have ports frame_done  out  1  one-cycle pulse; frame_motion_count  out  CNT_W  motion pixels of last frame, CNT_W=$clog2(IMG_W*IMG_H+1).

Function
REQ-009 SHALL pack raster-order bits LSB first: pixel at column c lands in bit (c mod WORD_W) of its word.
REQ-010 SHALL close a word when bit WORD_W-1 or column IMG_W-1 is accepted; unused upper bits of a line-end word are 0.
REQ-011 SHALL present a closed word on out_valid the cycle after its last bit is accepted (latency 1).
REQ-012 SHALL drive in_ready = enable && !clear && (!out_valid || out_ready); no bit is ever dropped.
REQ-013 SHALL hold out_data/out_eol/out_eof stable while out_valid && !out_ready.
REQ-014 SHALL deassert out_valid after a handshake unless a new word closes in that same cycle (back-to-back allowed).
REQ-015 SHALL keep column and row counters; column wraps at IMG_W-1 to 0 and increments row; row wraps at IMG_H-1 to 0.
REQ-016 SHALL set out_eol on the column-(IMG_W-1) word, and out_eof additionally when row is IMG_H-1.
REQ-017 SHALL pulse frame_done for exactly one cycle on the handshake of the out_eof word.
REQ-018 SHALL, with enable low, accept no bits, retain partial word and counters, and still drain a pending output word.
REQ-019 SHALL, on clear high, discard partial word, pending output word (out_valid<=0), and zero column/row; clear wins over a simultaneous in_valid.
REQ-020 SHALL implement FSM states PACK (accepting), HOLD (output full, out_ready low), with PACK->HOLD on word close with out_ready low, HOLD->PACK on handshake.

Reset
REQ-021 SHALL on rst_n low clear out_valid, out_data, out_eol, out_eof, frame_done, frame_motion_count, partial word, counters; state PACK.
REQ-022 SHALL apply reset immediately (asynchronously) mid-frame, mid-word, or mid-stall; first bit after release is bit 0, row 0, column 0.

Configuration
REQ-023 SHALL, with MMP_STATS_EN defined, count accepted in_motion=1 bits per frame and load the count into frame_motion_count on the cycle the out_eof word closes; counter clears on clear and frame end.
REQ-024 SHALL, without MMP_STATS_EN, keep the frame_motion_count port and drive it constant 0, with no counter logic.

Structure
REQ-025 SHALL place WORD_W default, IMG_W/IMG_H defaults, and the packer state enum in a shared package motion_map_pkg.
REQ-026 SHALL be a single module; no sub-module is required.

Verification (IMG_W=40, IMG_H=2, WORD_W=32)
REQ-027 SHALL check: rst_n low after 10 bits -> all outputs 0 asynchronously; next 32 ones -> out_data=0xFFFF_FFFF.
REQ-028 SHALL check: line of 32 ones then 8 bits 1,0,1,0,1,0,1,0 -> words 0xFFFF_FFFF (eol=0) then 0x0000_0055 (eol=1, eof=0).
REQ-029 SHALL check: out_ready low 5 cycles with word pending -> in_ready=0, out_data stable, no word lost after release.
REQ-030 SHALL check: 80 pixels streamed -> 4 words, last has eol=1, eof=1; frame_done exactly once; pixel 81 packs into bit 0.
REQ-031 SHALL check: clear after 10 bits -> partial discarded, out_valid=0; next 32 bits form a fresh word.
REQ-032 SHALL check (MMP_STATS_EN): 37 ones in a frame -> frame_motion_count=37 at frame end; without macro -> 0.
